// File: rtl/de10_linux_nios2_gen2_0_cpu_mult_combine.sv
// de10_linux_nios2_gen2_0_cpu_mult_combine: two-stage combine of 16x16 partial products into the low 32 bits of a 32x32 product
// Optional output-transfer counter W_mul_count enabled by MULT_COMBINE_PERFCNT_EN.
module de10_linux_nios2_gen2_0_cpu_mult_combine (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic [4:0]  M_mul_tag,
  input  logic        M_mul_valid,
  output logic        M_mul_ready,
  input  logic        M_flush,
  output logic [31:0] W_mul_result,
  output logic [4:0]  W_mul_tag,
  output logic        W_mul_valid,
  input  logic        W_mul_ready
`ifdef MULT_COMBINE_PERFCNT_EN
  ,
  output logic [31:0] W_mul_count
`endif
);
  logic        r_a_valid, r_b_valid;
  logic [31:0] r_a_p1, r_b_result;
  logic [15:0] r_a_cross;
  logic [4:0]  r_a_tag, r_b_tag;
  logic        w_adv, w_in_xfer, w_out_xfer;
  logic [15:0] w_cross;
  logic        w_unused;
  assign w_adv       = !r_b_valid || W_mul_ready;
  assign M_mul_ready = !r_a_valid || w_adv;
  assign w_in_xfer   = M_mul_valid && M_mul_ready && !M_flush;
  assign w_out_xfer  = r_b_valid && W_mul_ready && !M_flush;
  // Upper halves of the cross products only affect bits above 31.
  assign w_cross     = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
  assign w_unused    = &{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};
  assign W_mul_result = r_b_result;
  assign W_mul_tag    = r_b_tag;
  assign W_mul_valid  = r_b_valid;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_valid  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_a_p1     <= '0;
      r_a_cross  <= '0;
      r_a_tag    <= '0;
      r_b_result <= '0;
      r_b_tag    <= '0;
    end else begin
      r_a_valid <= M_flush ? 1'b0 : (M_mul_ready ? M_mul_valid : r_a_valid);
      r_b_valid <= M_flush ? 1'b0 : (w_adv ? r_a_valid : r_b_valid);
      if (w_in_xfer) begin
        r_a_p1    <= M_mul_cell_p1;
        r_a_cross <= w_cross;
        r_a_tag   <= M_mul_tag;
      end
      if (w_adv && r_a_valid && !M_flush) begin
        r_b_result <= r_a_p1 + {r_a_cross, 16'h0000};
        r_b_tag    <= r_a_tag;
      end
    end
  end
`ifdef MULT_COMBINE_PERFCNT_EN
  logic [31:0] r_count;
  assign W_mul_count = r_count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_count <= '0;
    else if (w_out_xfer) r_count <= r_count + 32'd1;
  end
`else
  logic w_unused_out;
  assign w_unused_out = w_out_xfer;
`endif
endmodule

// File: tb/tb_de10_linux_nios2_gen2_0_cpu_mult_combine.sv
// tb_de10_linux_nios2_gen2_0_cpu_mult_combine: random and directed traffic checked against a queue-based model.
module tb_de10_linux_nios2_gen2_0_cpu_mult_combine;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [31:0] p1 = '0, p2 = '0, p3 = '0;
  logic [4:0]  tag = '0;
  logic        mv = 1'b0, fl = 1'b0, wr = 1'b0;
  logic        M_mul_ready, W_mul_valid;
  logic [31:0] W_mul_result;
  logic [4:0]  W_mul_tag;
  int          total = 0, bad = 0;
  logic [36:0] q[$];
  bit          pres = 0;
  logic [31:0] cnt = '0;
`ifdef MULT_COMBINE_PERFCNT_EN
  logic [31:0] W_mul_count;
`endif
  always #5 clk = ~clk;
  de10_linux_nios2_gen2_0_cpu_mult_combine dut (
    .clk(clk), .reset_n(reset_n),
    .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
    .M_mul_tag(tag), .M_mul_valid(mv), .M_mul_ready(M_mul_ready), .M_flush(fl),
    .W_mul_result(W_mul_result), .W_mul_tag(W_mul_tag), .W_mul_valid(W_mul_valid),
    .W_mul_ready(wr)
`ifdef MULT_COMBINE_PERFCNT_EN
    , .W_mul_count(W_mul_count)
`endif
  );
  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask
  task automatic check_out();
    chk("valid", {63'd0, W_mul_valid}, {63'd0, pres});
    chk("ready", {63'd0, M_mul_ready}, {63'd0, q.size() < 2 || wr});
    if (pres) begin
      chk("result", {32'd0, W_mul_result}, {32'd0, q[0][31:0]});
      chk("tag", {59'd0, W_mul_tag}, {59'd0, q[0][36:32]});
    end
`ifdef MULT_COMBINE_PERFCNT_EN
    chk("count", {32'd0, W_mul_count}, {32'd0, cnt});
`endif
  endtask
  task automatic step(input bit v, input logic [31:0] a, b, c, input logic [4:0] t,
                      input bit w, input bit f, output bit acc);
    logic [31:0] r;
    bit er, out;
    mv = v; p1 = a; p2 = b; p3 = c; tag = t; wr = w; fl = f;
    #1 check_out();
    er = q.size() < 2 || w;
    out = pres && w;
    acc = v && er && !f;
    @(posedge clk);
    if (f) begin
      q.delete();
      pres = 0;
    end else begin
      if (out) begin
        void'(q.pop_front());
        cnt++;
      end
      pres = q.size() > 0;
      r = a + ((b + c) << 16);
      if (acc) q.push_back({t, r});
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 0, a);
  endtask
  initial begin
    bit a;
    int k;
    #1;
    chk("rst_valid", {63'd0, W_mul_valid}, 64'd0);
    chk("rst_result", {32'd0, W_mul_result}, 64'd0);
    chk("rst_tag", {59'd0, W_mul_tag}, 64'd0);
    chk("rst_ready", {63'd0, M_mul_ready}, 64'd1);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    step(1, 32'h8, 32'h6, 32'h4, 5'd3, 1, 0, a);
    step(0, 0, 0, 0, 0, 1, 0, a);
    chk("basic_result", {32'd0, W_mul_result}, 64'h000A0008);
    chk("basic_tag", {59'd0, W_mul_tag}, 64'd3);
    idle(2);
    step(1, 32'h12345678, 32'h00008000, 32'hFFFF8000, 5'd7, 1, 0, a);
    step(0, 0, 0, 0, 0, 1, 0, a);
    chk("carry_result", {32'd0, W_mul_result}, 64'h12345678);
    idle(2);
    k = 1;
    for (int i = 0; i < 5; i++) begin
      step(k <= 4, $urandom, $urandom, $urandom, k[4:0], 0, 0, a);
      if (a) k++;
    end
    chk("bp_accepts", k, 3);
    for (int i = 0; i < 8; i++) begin
      step(k <= 4, $urandom, $urandom, $urandom, k[4:0], 1, 0, a);
      if (a) k++;
    end
    step(1, $urandom, $urandom, $urandom, 5'd9, 0, 0, a);
    step(1, $urandom, $urandom, $urandom, 5'd10, 0, 0, a);
    step(1, $urandom, $urandom, $urandom, 5'd11, 1, 1, a);
    chk("flush_valid", {63'd0, W_mul_valid}, 64'd0);
    idle(3);
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, W_mul_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, M_mul_ready}, 64'd1);
        q.delete();
        pres = 0;
        cnt = '0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, 5'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, a);
    end
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/de10_linux_nios2_gen2_0_cpu_mult_combine.md
DE10_LINUX_NIOS2_GEN2_0_CPU_MULT_COMBINE -- requirements
Module: de10_linux_nios2_gen2_0_cpu_mult_combine

Interface
REQ-001 SHALL have no parameters; all widths are fixed: data 32, tag 5.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, input, 32 bits each: the 16x16 unsigned partial products lo1*lo2, lo1*hi2 and hi1*lo2.
REQ-005 SHALL have port M_mul_tag, input, 5 bits: destination register index carried alongside the data.
REQ-006 SHALL have port M_mul_valid, input, 1 bit: the partial products and tag are valid this cycle.
REQ-007 SHALL have port M_mul_ready, output, 1 bit: the block accepts the input this cycle.
REQ-008 SHALL have port M_flush, input, 1 bit: pipeline kill.
REQ-009 SHALL have port W_mul_result, output, 32 bits: low 32 bits of the product.
REQ-010 SHALL have port W_mul_tag, output, 5 bits: tag of the result currently presented.
REQ-011 SHALL have port W_mul_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port W_mul_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-013 SHALL define a transfer as valid and ready both high at a rising edge, on both the input and output sides.
REQ-014 SHALL implement a two-stage registered pipeline, A then B, each stage holding a valid bit.
- Stage A loads p1 and cross = (p2[15:0] + p3[15:0]) mod 2^16.
- Stage B loads result = (p1_A + {cross_A, 16'h0000}) mod 2^32.
REQ-015 SHALL never use p2[31:16] or p3[31:16]; all carries out of bit 15 of cross and out of bit 31 of result are discarded.
REQ-016 SHALL advance stage B when B is empty or the output transfers; stage A SHALL advance into B under the same condition.
REQ-017 SHALL drive M_mul_ready = !A_valid OR (stage A advances this cycle), so back-to-back inputs sustain one result per cycle.
REQ-018 SHALL make a result visible two cycles after acceptance: input accepted at edge N gives W_mul_valid high after edge N+1 when W_mul_ready stays high.
REQ-019 SHALL hold W_mul_result, W_mul_tag and W_mul_valid stable while W_mul_valid=1 and W_mul_ready=0.
REQ-020 SHALL keep both stages full and deassert M_mul_ready under sustained backpressure, with no data loss and no duplication.
REQ-021 SHALL, when M_flush=1 at an edge, clear A_valid and B_valid and discard any input offered in that cycle; flush SHALL win over simultaneous input and output transfers.
REQ-022 SHALL keep data registers unchanged when their stage does not load; only the valid bits are affected by flush.
REQ-023 SHALL keep the tag paired with its data through both stages.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously clear A_valid, B_valid, all data and tag registers, and the counter.
REQ-025 SHALL give these output values during reset: W_mul_valid=0, W_mul_result=0, W_mul_tag=0, M_mul_ready=1.
REQ-026 SHALL, on reset mid-operation, lose all in-flight results and emit no partial output after release.

Configuration
REQ-027 SHALL, when macro MULT_COMBINE_PERFCNT_EN is defined, add output W_mul_count (32 bits, reset 0).
- W_mul_count increments by 1 on each output transfer and wraps from 0xFFFFFFFF to 0.
- W_mul_count is not cleared by M_flush.
REQ-028 SHALL, when MULT_COMBINE_PERFCNT_EN is undefined, omit the W_mul_count port and the counter logic entirely; all other behaviour is identical.

Verification
REQ-029 Basic product: p1=0x00000008, p2=0x00000006, p3=0x00000004, tag=3, W_mul_ready=1 -> two cycles later W_mul_result=0x000A0008, W_mul_tag=3, W_mul_valid high for 1 cycle.
REQ-030 Carry discard: p1=0x12345678, p2=0x00008000, p3=0xFFFF8000 -> W_mul_result=0x12345678.
REQ-031 Backpressure: 4 back-to-back inputs with tags 1..4, W_mul_ready=0 for 5 cycles then 1 -> M_mul_ready low after 2 accepts; outputs tags 1,2,3,4 in order on consecutive cycles, with no loss.
REQ-032 Flush: flush asserted while both stages are full and a new input is offered -> W_mul_valid=0 next cycle and no result for any of the three.
REQ-033 Reset: reset_n pulled low mid-stream -> W_mul_valid=0 immediately and M_mul_ready=1; after release, no stale output.
REQ-034 Counter (macro defined): counter preset near wrap via 0xFFFFFFFF output transfers, or forced, then 2 more transfers -> W_mul_count=0x00000001; a flush leaves W_mul_count unchanged.
